// File: rtl/request_arbiter_unit_pkg.sv
// Shared types and defaults for the request arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package request_arbiter_unit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int DEF_NCH     = 2;
    localparam int DEF_TIMEOUT = 255;

    // Channel index width; a single channel still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/request_arbiter_if.sv
// Request/memory handshake bundle between channels and the arbiter.
// Latency: n/a (wires only).
// Backpressure: dhit is the only completion/stall signal from memory.
interface request_arbiter_if
    import request_arbiter_unit_pkg::*;
#(
    parameter int NCH = DEF_NCH
) ();
    localparam int SW = sel_width(NCH);

    logic [NCH-1:0] ihit;
    logic [NCH-1:0] dren;
    logic [NCH-1:0] dwen;
    logic           dhit;
    logic           dmemren;
    logic           dmemwen;
    logic [SW-1:0]  dsel;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] done;
    logic           timeout_err;

    modport ru (
        input  ihit, dren, dwen, dhit,
        output dmemren, dmemwen, dsel, pending, done, timeout_err
    );

    modport tb (
        output ihit, dren, dwen, dhit,
        input  dmemren, dmemwen, dsel, pending, done, timeout_err
    );

endinterface

// File: rtl/request_arbiter_unit_rr_select.sv
// Round-robin pick of the first set request at or after ptr.
// Latency: purely combinational.
// Backpressure: none; vld=0 when no request is set.
module rr_select
    import request_arbiter_unit_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    localparam int SW = sel_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    output logic           vld,
    output logic [SW-1:0]  idx
);

    always_comb begin
        int            j;
        logic [SW-1:0] cand;
        vld  = 1'b0;
        idx  = '0;
        j    = 0;
        cand = '0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr) + i;
            if (j >= NCH) begin
                j = j - NCH;
            end
            cand = SW'(j);
            if (!vld && req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/request_arbiter_unit.sv
// Arbitrates per-channel read/write requests onto one memory port, round-robin.
// Latency: capture at edge N, grant and strobe from edge N+1 until dhit; done one cycle after dhit.
// Backpressure: access held until dhit or TIMEOUT busy cycles, then aborted with sticky error.
module request_arbiter_unit
    import request_arbiter_unit_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    request_arbiter_if.ru bus
);

    localparam int SW = sel_width(NCH);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] done_q, done_d;
    op_t            op_q [NCH];
    op_t            op_d [NCH];
    logic [SW-1:0]  dsel_q, dsel_d;
    logic [SW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dmemren_q, dmemren_d;
    logic           dmemwen_q, dmemwen_d;
    logic           terr_q, terr_d;

    logic           rr_vld;
    logic [SW-1:0]  rr_idx;
    logic           complete;
    logic           release_ch;
    logic [NCH-1:0] cap;

    rr_select #(.NCH(NCH)) u_rr_select (
        .req (pending_q),
        .ptr (rr_ptr_q),
        .vld (rr_vld),
        .idx (rr_idx)
    );

    assign cap      = bus.ihit & (bus.dren | bus.dwen);
    assign complete = (state_q == BUSY) && bus.dhit;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        op_d       = op_q;
        dsel_d     = dsel_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        done_d     = '0;
        terr_d     = terr_q;
        dmemren_d  = 1'b0;
        dmemwen_d  = 1'b0;
        release_ch = 1'b0;

        case (state_q)
            IDLE: begin
                if (rr_vld) begin
                    state_d   = BUSY;
                    dsel_d    = rr_idx;
                    cnt_d     = '0;
                    dmemren_d = (op_q[rr_idx] == OP_READ);
                    dmemwen_d = (op_q[rr_idx] == OP_WRITE);
                end
            end
            BUSY: begin
                // dhit on the final allowed cycle still counts as completion
                if (bus.dhit) begin
                    done_d[dsel_q] = 1'b1;
                    release_ch     = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    terr_d     = 1'b1;
                    release_ch = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    dmemren_d = dmemren_q;
                    dmemwen_d = dmemwen_q;
                end
                if (release_ch) begin
                    pending_d[dsel_q] = 1'b0;
                    state_d           = IDLE;
                    rr_ptr_d          = (dsel_q == SW'(NCH - 1)) ? '0 : dsel_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request on the channel being completed overrides its clear.
        for (int c = 0; c < NCH; c++) begin
            if (cap[c] && (!pending_q[c] || (complete && dsel_q == SW'(c)))) begin
                pending_d[c] = 1'b1;
                op_d[c]      = bus.dwen[c] ? OP_WRITE : OP_READ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= '0;
            dsel_q    <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            dmemren_q <= 1'b0;
            dmemwen_q <= 1'b0;
            terr_q    <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                op_q[c] <= OP_READ;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            dsel_q    <= dsel_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            dmemren_q <= dmemren_d;
            dmemwen_q <= dmemwen_d;
            terr_q    <= terr_d;
            op_q      <= op_d;
        end
    end

    assign bus.dmemren     = dmemren_q;
    assign bus.dmemwen     = dmemwen_q;
    assign bus.dsel        = dsel_q;
    assign bus.pending     = pending_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;

endmodule
